// File: rtl/cache_access_gen.sv
// cache_access_gen: programmable address-stream generator for the L1 request port.
// Produces SEQ / LOOP / RAND / DESC address streams under a valid/ready handshake
// and counts accepted beats. All address arithmetic wraps modulo 2^ADDR_WIDTH.
// ADDR_WIDTH must not exceed 16, since RAND takes its offset from the 16-bit LFSR.
module cache_access_gen #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [LEN_WIDTH-1:0]  win_len,
    input  logic                  abort,
    output logic                  req_valid,
    output logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_ready,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           issued_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_SEQ  = 2'd0,
        MODE_LOOP = 2'd1,
        MODE_RAND = 2'd2,
        MODE_DESC = 2'd3
    } mode_e;

    state_e                state;
    mode_e                 mode_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [LEN_WIDTH-1:0]  length_q;
    logic [LEN_WIDTH-1:0]  win_q;      // effective window, never 0
    logic [LEN_WIDTH-1:0]  beat_idx;   // index of the beat currently offered
    logic [LEN_WIDTH-1:0]  win_idx;    // position inside the LOOP window
    logic [15:0]           lfsr;

    logic [15:0]           lfsr_step;
    logic                  win_wrap;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] first_addr;

    // Next-beat address, LFSR advance and end-of-stream / end-of-window detection
    always_comb begin
        // Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 in right-shift form)
        lfsr_step  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        win_wrap   = (win_idx == win_q - LEN_WIDTH'(1));
        last_beat  = (beat_idx == length_q - LEN_WIDTH'(1));
        first_addr = (mode_e'(mode) == MODE_RAND) ? base_addr + LFSR_SEED[ADDR_WIDTH-1:0]
                                                  : base_addr;
        next_addr  = req_addr;
        case (mode_q)
            MODE_SEQ:  next_addr = req_addr + stride_q;
            MODE_LOOP: next_addr = win_wrap ? base_q : req_addr + stride_q;
            MODE_RAND: next_addr = base_q + lfsr_step[ADDR_WIDTH-1:0];
            MODE_DESC: next_addr = req_addr - stride_q;
            default:   next_addr = req_addr;
        endcase
    end

    // Control FSM with registered handshake outputs, command latch and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            // NOTE: command registers are reset too, so a mid-stream reset leaves
            // no stale stream parameters behind for the next command to trip over.
            mode_q       <= MODE_SEQ;
            base_q       <= '0;
            stride_q     <= '0;
            length_q     <= '0;
            win_q        <= '0;
            beat_idx     <= '0;
            win_idx      <= '0;
            lfsr         <= LFSR_SEED;
            req_valid    <= 1'b0;
            req_addr     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            issued_count <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below sees
            // the pre-edge register values regardless of statement order.
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q       <= mode_e'(mode);
                        base_q       <= base_addr;
                        stride_q     <= stride;
                        length_q     <= length;
                        win_q        <= (win_len == '0) ? LEN_WIDTH'(1) : win_len;
                        beat_idx     <= '0;
                        win_idx      <= '0;
                        lfsr         <= LFSR_SEED;
                        issued_count <= '0;
                        if (length != '0) begin
                            state     <= ST_RUN;
                            req_valid <= 1'b1;
                            busy      <= 1'b1;
                            req_addr  <= first_addr;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // req_valid is always high here, so ready alone is a handshake;
                    // abort takes priority and the coincident beat is dropped
                    if (abort) begin
                        state     <= ST_DONE;
                        req_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (req_ready) begin
                        issued_count <= issued_count + 32'd1;
                        lfsr         <= lfsr_step;
                        if (last_beat) begin
                            state     <= ST_DONE;
                            req_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            beat_idx <= beat_idx + LEN_WIDTH'(1);
                            win_idx  <= win_wrap ? '0 : win_idx + LEN_WIDTH'(1);
                            req_addr <= next_addr;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_access_gen.sv
// Self-checking bench for cache_access_gen: directed streams with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model that computes beat addresses directly from the beat index.
module tb_cache_access_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [10:0] base_addr;
    logic [10:0] stride;
    logic [15:0] length;
    logic [15:0] win_len;
    logic        abort;
    logic        req_valid;
    logic [10:0] req_addr;
    logic        req_ready;
    logic        busy;
    logic        done;
    logic [31:0] issued_count;

    int n_checks = 0;
    int n_errors = 0;

    cache_access_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode         (mode),
        .base_addr    (base_addr),
        .stride       (stride),
        .length       (length),
        .win_len      (win_len),
        .abort        (abort),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .busy         (busy),
        .done         (done),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Address of beat i straight from the stream definition
    function automatic logic [10:0] model_addr(int md, int b, int s, int w, int i);
        int v;
        int l;
        int fb;
        v = 0;
        case (md)
            0: v = b + i * s;
            1: v = b + (i % w) * s;
            2: begin
                l = 'hACE1;
                for (int k = 0; k < i; k++) begin
                    fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
                    l  = (l >> 1) | (fb << 15);
                end
                v = b + (l & 'h7FF);
            end
            default: v = b - i * s;
        endcase
        return v[10:0];
    endfunction

    // Behavioural model: stream active flag, beat index and accepted count
    bit          m_active;
    bit          m_done;
    int          m_i;
    logic [31:0] m_count;
    int          m_mode, m_base, m_stride, m_len, m_win;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_i      <= 0;
            m_count  <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_mode   <= int'(mode);
                m_base   <= int'(base_addr);
                m_stride <= int'(stride);
                m_len    <= int'(length);
                m_win    <= (win_len == 0) ? 1 : int'(win_len);
                m_i      <= 0;
                m_count  <= '0;
                if (length == 0) m_done <= 1'b1;
                else             m_active <= 1'b1;
            end
        end else if (abort) begin
            m_active <= 1'b0;
            m_done   <= 1'b1;
        end else if (req_ready) begin
            m_count <= m_count + 32'd1;
            m_i     <= m_i + 1;
            if (m_i + 1 == m_len) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            check("valid", 32'(req_valid), 32'(m_active));
            check("busy", 32'(busy), 32'(m_active));
            check("done", 32'(done), 32'(m_done));
            check("count", issued_count, m_count);
            if (m_active)
                check("addr", 32'(req_addr), 32'(model_addr(m_mode, m_base, m_stride, m_win, m_i)));
        end
    end

    // Observers: accepted addresses, done pulses, cycles with valid high
    logic [10:0] acc_q[$];
    logic [10:0] exp_q[$];
    logic [10:0] ref_q[$];
    int          done_cnt  = 0;
    int          valid_cnt = 0;

    always @(posedge clk) begin
        if (rst_n && req_valid && req_ready && !abort) acc_q.push_back(req_addr);
    end

    always @(negedge clk) begin
        if (rst_n && done)      done_cnt  <= done_cnt + 1;
        if (rst_n && req_valid) valid_cnt <= valid_cnt + 1;
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_stream(input string name);
        check({name, "_len"}, acc_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++)
            check(name, 32'(acc_q[k]), 32'(exp_q[k]));
    endtask

    // Issue one command and wait (bounded) for its done pulse.
    // stall=0: ready held high; stall=1: ready pattern 1,0,0 repeating.
    task automatic run_cmd(input int md, input int b, input int s, input int len,
                           input int w, input int stall);
        int n;
        int d0;
        acc_q.delete();
        d0        = done_cnt;
        start     = 1'b1;
        mode      = 2'(md);
        base_addr = 11'(b);
        stride    = 11'(s);
        length    = 16'(len);
        win_len   = 16'(w);
        req_ready = 1'b1;
        cycle();
        start     = 1'b0;
        mode      = 2'($urandom);
        base_addr = 11'($urandom);
        stride    = 11'($urandom);
        length    = 16'($urandom);
        win_len   = 16'($urandom);
        n = 1;
        while (done_cnt == d0 && n < 300) begin
            req_ready = (stall == 0) ? 1'b1 : (n % 3 == 0);
            cycle();
            n++;
        end
        if (done_cnt == d0) begin
            n_errors++;
            $display("FAIL timeout: no done pulse within %0d cycles", n);
        end
        req_ready = 1'b0;
        cycle();
    endtask

    initial begin
        int d0;
        int v0;
        rst_n     = 1'b0;
        start     = 1'b0;
        mode      = '0;
        base_addr = '0;
        stride    = '0;
        length    = '0;
        win_len   = '0;
        abort     = 1'b0;
        req_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", 32'(req_valid), 32'd0);
        check("rst_addr", 32'(req_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", issued_count, 32'd0);
        rst_n = 1'b1;
        cycle();

        // SEQ basic
        run_cmd(0, 'h100, 4, 4, 0, 0);
        exp_q = '{11'h100, 11'h104, 11'h108, 11'h10C};
        check_stream("seq");
        check("seq_count", issued_count, 32'd4);

        // LOOP window 3
        run_cmd(1, 'h000, 'h40, 7, 3, 0);
        exp_q = '{11'h000, 11'h040, 11'h080, 11'h000, 11'h040, 11'h080, 11'h000};
        check_stream("loop");

        // LOOP with win_len 0 behaves as a window of 1
        run_cmd(1, 'h050, 8, 3, 0, 0);
        exp_q = '{11'h050, 11'h050, 11'h050};
        check_stream("loop_w0");

        // Wrap upward and DESC wrap downward
        run_cmd(0, 'h7FC, 4, 3, 0, 0);
        exp_q = '{11'h7FC, 11'h000, 11'h004};
        check_stream("seq_wrap");
        run_cmd(3, 'h004, 4, 3, 0, 0);
        exp_q = '{11'h004, 11'h000, 11'h7FC};
        check_stream("desc_wrap");

        // RAND without and with backpressure
        run_cmd(2, 'h123, 0, 12, 0, 0);
        ref_q = acc_q;
        check("rand_b0", 32'(acc_q.size() > 0 ? acc_q[0] : 11'h0), 32'h604);
        check("rand_b1", 32'(acc_q.size() > 1 ? acc_q[1] : 11'h0), 32'h793);
        run_cmd(2, 'h123, 0, 12, 0, 1);
        exp_q = ref_q;
        check_stream("rand_stall");
        check("rand_count", issued_count, 32'(acc_q.size()));

        // length 0: done pulse, no valid
        v0 = valid_cnt;
        d0 = done_cnt;
        run_cmd(0, 'h200, 1, 0, 0, 0);
        check("len0_valid", 32'(valid_cnt - v0), 32'd0);
        check("len0_done", 32'(done_cnt - d0), 32'd1);

        // Abort coincident with the 3rd handshake, plus start while busy
        acc_q.delete();
        d0        = done_cnt;
        start     = 1'b1;
        mode      = 2'd0;
        base_addr = 11'h300;
        stride    = 11'h1;
        length    = 16'd10;
        win_len   = 16'd0;
        req_ready = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        abort = 1'b1;
        start = 1'b1;
        cycle();
        abort = 1'b0;
        start = 1'b0;
        repeat (3) cycle();
        check("abort_count", issued_count, 32'd2);
        check("abort_beats", 32'(acc_q.size()), 32'd2);
        check("abort_done", 32'(done_cnt - d0), 32'd1);
        check("abort_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-stream
        d0        = done_cnt;
        start     = 1'b1;
        mode      = 2'd0;
        base_addr = 11'h055;
        stride    = 11'h3;
        length    = 16'd20;
        req_ready = 1'b1;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(req_valid), 32'd0);
        check("arst_addr", 32'(req_addr), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_count", issued_count, 32'd0);
        #10 rst_n = 1'b1;
        repeat (3) cycle();
        check("arst_no_done", 32'(done_cnt - d0), 32'd0);

        // Randomized traffic, checked each cycle by the model
        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom_range(0, 3) == 0);
            mode      = 2'($urandom);
            base_addr = 11'($urandom);
            stride    = 11'($urandom);
            length    = 16'($urandom_range(0, 12));
            win_len   = 16'($urandom_range(0, 5));
            abort     = ($urandom_range(0, 29) == 0);
            req_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        start     = 1'b0;
        abort     = 1'b0;
        req_ready = 1'b1;
        repeat (20) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
